multicycle_controller: RTL and testbench
========================================

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 Parameter SUPPORT_ADDI, default 1, meaning: when 1, decode addi (op 001000); when 0, treat it as illegal.
REQ-002 Parameter SUPPORT_BNE, default 1, meaning: when 1, decode bne (op 000101); when 0, treat it as illegal.
REQ-003 Parameter MEM_WAIT, default 1, meaning: when 1, memory states wait for mem_ready; when 0, mem_ready is ignored and treated as 1.
REQ-004 Parameter CNT_W, default 16, meaning: width of the retired-instruction counter.
REQ-005 The design SHALL use one clock; reset is synchronous and active-high.
REQ-006 Ports SHALL be, listed as name, direction, width, meaning:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- op  in  6  instruction[31:26], valid from DECODE onward.
- funct  in  6  instruction[5:0].
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory access completes this cycle.
- iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca  out  1 each  datapath controls.
- alusrcb  out  2  00 reg B, 01 constant 4, 10 sign-extended immediate, 11 immediate<<2.
- pcsrc  out  2  00 ALU result, 01 ALUOut, 10 jump target.
- alucontrol  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt.
- pcen  out  1  PC write enable.
- illegal  out  1  one-cycle pulse on an undecodable instruction.
- state  out  4  current FSM state, for debug.
- retired  out  CNT_W  count of completed instructions.

Function
REQ-007 The FSM SHALL have the states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPEEX, RTYPEWB, BEQEX, BNEEX, ADDIEX, ADDIWB and JEX, each with a fixed 4-bit encoding.
REQ-008 All outputs except pcen SHALL be Moore outputs, decoded from the state register only; pcen SHALL be combinational.
REQ-009 FETCH SHALL assert iord=0, alusrca=0, alusrcb=01, alucontrol=010, pcsrc=00, irwrite and pcwrite, gated by the memory-done condition.
- Memory-done condition: mem_ready=1, or MEM_WAIT=0.
- If the condition is false, FETCH SHALL hold with irwrite=0 and pcwrite=0.
- If the condition is true, the FSM SHALL go to DECODE.
REQ-010 DECODE SHALL drive alusrca=0, alusrcb=11, alucontrol=010, then branch on op:
- lw/sw -> MEMADR.
- R-type (000000) -> RTYPEEX.
- beq (000100) -> BEQEX.
- bne -> BNEEX.
- addi -> ADDIEX.
- j (000010) -> JEX.
- Any other op, or a disabled op -> FETCH, with illegal=1 for that DECODE cycle.
REQ-011 MEMADR SHALL drive alusrca=1, alusrcb=10, alucontrol=010, then go to MEMRD for lw or MEMWR for sw.
REQ-012 MEMRD SHALL assert iord=1, holding until the memory-done condition, then go to MEMWB.
REQ-013 MEMWR SHALL assert iord=1 and memwrite=1 for every cycle spent in the state.
- It SHALL hold until the memory-done condition, then go to FETCH.
REQ-014 MEMWB SHALL assert regwrite=1, memtoreg=1, regdst=0, then go to FETCH.
REQ-015 RTYPEEX SHALL drive alusrca=1, alusrcb=00 and map funct to alucontrol:
- 100000 -> 010; 100010 -> 110; 100100 -> 000; 100101 -> 001; 101010 -> 111.
- On a listed funct, the FSM SHALL go to RTYPEWB.
- On any other funct, alucontrol SHALL be 010, illegal SHALL be 1, and the FSM SHALL go to FETCH with no writeback.
REQ-016 RTYPEWB SHALL assert regwrite=1, regdst=1, memtoreg=0, then go to FETCH.
REQ-017 BEQEX and BNEEX SHALL drive alusrca=1, alusrcb=00, alucontrol=110, pcsrc=01, then go to FETCH.
REQ-018 pcen SHALL equal:
- (FETCH pcwrite), or
- (BEQEX & zero), or
- (BNEEX & ~zero), or
- JEX.
REQ-019 ADDIEX SHALL drive alusrca=1, alusrcb=10, alucontrol=010, then go to ADDIWB.
REQ-020 ADDIWB SHALL assert regwrite=1, regdst=0, memtoreg=0, then go to FETCH.
REQ-021 JEX SHALL drive pcsrc=10, then go to FETCH.
REQ-022 All controls not listed for a state SHALL be 0.
REQ-023 retired SHALL increment by 1, modulo 2^CNT_W, on each transition into FETCH from one of:
- MEMWB, MEMWR (when done), RTYPEWB, BEQEX, BNEEX, ADDIWB, JEX.
REQ-024 Illegal-instruction exits SHALL NOT increment retired.
REQ-025 Instruction latencies SHALL be, with zero memory wait:
- lw: 5 cycles.
- sw: 4 cycles.
- R-type: 4 cycles.
- addi: 4 cycles.
- beq/bne: 3 cycles.
- j: 3 cycles.
REQ-026 Each cycle of mem_ready=0 in FETCH, MEMRD or MEMWR SHALL add exactly one cycle of latency.

Reset
REQ-027 When reset=1 at a clock edge, state SHALL become FETCH and retired SHALL become 0, regardless of the current state, including mid-wait in MEMRD or MEMWR.
REQ-028 In the cycle after reset, all outputs SHALL be the FETCH values and illegal SHALL be 0.
- Reset SHALL take priority over every transition and over the counter increment.

Verification
REQ-029 lw with mem_ready=1 throughout -> state sequence FETCH, DECODE, MEMADR, MEMRD, MEMWB, FETCH; regwrite=1 and memtoreg=1 in MEMWB only; retired 0 -> 1.
REQ-030 sw with mem_ready held 0 for 3 cycles in MEMWR -> memwrite=1 for 4 cycles; FSM returns to FETCH after; retired increments once.
REQ-031 beq with zero=1, then bne with zero=1 -> pcen=1 in BEQEX, pcen=0 in BNEEX; retired +2.
REQ-032 R-type with funct 101010 -> alucontrol=111 in RTYPEEX; funct 000000 -> illegal pulse, no regwrite, retired unchanged.
REQ-033 Build with SUPPORT_ADDI=0 and issue op 001000 -> illegal=1 in DECODE, next state FETCH; op 000101 with SUPPORT_BNE=1 -> BNEEX.
REQ-034 Assert reset during MEMRD wait with retired=5 -> next cycle state=FETCH, retired=0, regwrite=0; retired counter wraps from 2^CNT_W-1 to 0 on the next completion.

Source files
------------

// File: rtl/multicycle_controller.sv
// Multicycle MIPS-subset control unit.
// A 13-state FSM sequences fetch, decode, execute, memory and writeback
// steps and drives the datapath controls for each step. It also counts
// retired instructions and flags opcodes or functs it cannot decode.
module multicycle_controller #(
   parameter int SUPPORT_ADDI = 1,
   parameter int SUPPORT_BNE  = 1,
   parameter int MEM_WAIT     = 1,
   parameter int CNT_W        = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [5:0]       op,
   input  logic [5:0]       funct,
   input  logic             zero,
   input  logic             mem_ready,
   output logic             iord,
   output logic             memwrite,
   output logic             irwrite,
   output logic             regdst,
   output logic             memtoreg,
   output logic             regwrite,
   output logic             alusrca,
   output logic [1:0]       alusrcb,
   output logic [1:0]       pcsrc,
   output logic [2:0]       alucontrol,
   output logic             pcen,
   output logic             illegal,
   output logic [3:0]       state,
   output logic [CNT_W-1:0] retired
);

   typedef enum logic [3:0] {
      FETCH   = 4'd0,
      DECODE  = 4'd1,
      MEMADR  = 4'd2,
      MEMRD   = 4'd3,
      MEMWB   = 4'd4,
      MEMWR   = 4'd5,
      RTYPEEX = 4'd6,
      RTYPEWB = 4'd7,
      BEQEX   = 4'd8,
      BNEEX   = 4'd9,
      ADDIEX  = 4'd10,
      ADDIWB  = 4'd11,
      JEX     = 4'd12
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   state_t           state_reg;
   state_t           state_next;
   logic [CNT_W-1:0] retired_reg;
   logic             retire_next;
   logic             mem_done;
   logic             pcwrite;
   logic             funct_ok;
   logic [2:0]       funct_alu;
   logic             op_ok;

   // A memory access completes this cycle (always true when waiting is disabled)
   assign mem_done = mem_ready | (MEM_WAIT == 0);

   // Map an R-type funct field to its ALU operation
   always_comb begin
      funct_ok  = 1'b1;
      funct_alu = 3'b010;
      case (funct)
         6'b100000: funct_alu = 3'b010;
         6'b100010: funct_alu = 3'b110;
         6'b100100: funct_alu = 3'b000;
         6'b100101: funct_alu = 3'b001;
         6'b101010: funct_alu = 3'b111;
         default:   funct_ok  = 1'b0;
      endcase
   end

   // Decide whether the opcode is supported by this build
   always_comb begin
      op_ok = 1'b0;
      case (op)
         OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_J: op_ok = 1'b1;
         OP_BNE:  op_ok = (SUPPORT_BNE != 0);
         OP_ADDI: op_ok = (SUPPORT_ADDI != 0);
         default: op_ok = 1'b0;
      endcase
   end

   // Next-state selection and detection of a completing instruction
   always_comb begin
      state_next  = state_reg;
      retire_next = 1'b0;
      case (state_reg)
         FETCH:   if (mem_done) state_next = DECODE;
         DECODE: begin
            case (op)
               OP_LW, OP_SW: state_next = MEMADR;
               OP_RTYPE:     state_next = RTYPEEX;
               OP_BEQ:       state_next = BEQEX;
               OP_BNE:       state_next = (SUPPORT_BNE != 0) ? BNEEX : FETCH;
               OP_ADDI:      state_next = (SUPPORT_ADDI != 0) ? ADDIEX : FETCH;
               OP_J:         state_next = JEX;
               default:      state_next = FETCH;
            endcase
         end
         MEMADR:  state_next = (op == OP_SW) ? MEMWR : MEMRD;
         MEMRD:   if (mem_done) state_next = MEMWB;
         MEMWR: begin
            if (mem_done) begin
               state_next  = FETCH;
               retire_next = 1'b1;
            end
         end
         RTYPEEX: state_next = funct_ok ? RTYPEWB : FETCH;
         ADDIEX:  state_next = ADDIWB;
         MEMWB, RTYPEWB, BEQEX, BNEEX, ADDIWB, JEX: begin
            state_next  = FETCH;
            retire_next = 1'b1;
         end
         default: state_next = FETCH;
      endcase
   end

   // State register and retired-instruction counter; reset overrides both
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg   <= FETCH;
         retired_reg <= '0;
      end else begin
         state_reg <= state_next;
         if (retire_next) retired_reg <= retired_reg + CNT_W'(1);
      end
   end

   // Datapath controls decoded from the current state
   always_comb begin
      iord       = 1'b0;
      memwrite   = 1'b0;
      irwrite    = 1'b0;
      regdst     = 1'b0;
      memtoreg   = 1'b0;
      regwrite   = 1'b0;
      alusrca    = 1'b0;
      alusrcb    = 2'b00;
      pcsrc      = 2'b00;
      alucontrol = 3'b000;
      illegal    = 1'b0;
      pcwrite    = 1'b0;
      case (state_reg)
         FETCH: begin
            alusrcb    = 2'b01;
            alucontrol = 3'b010;
            irwrite    = mem_done;
            pcwrite    = mem_done;
         end
         DECODE: begin
            alusrcb    = 2'b11;
            alucontrol = 3'b010;
            illegal    = ~op_ok;
         end
         MEMADR, ADDIEX: begin
            alusrca    = 1'b1;
            alusrcb    = 2'b10;
            alucontrol = 3'b010;
         end
         MEMRD:   iord = 1'b1;
         MEMWR: begin
            iord     = 1'b1;
            memwrite = 1'b1;
         end
         MEMWB: begin
            regwrite = 1'b1;
            memtoreg = 1'b1;
         end
         RTYPEEX: begin
            alusrca    = 1'b1;
            alucontrol = funct_ok ? funct_alu : 3'b010;
            illegal    = ~funct_ok;
         end
         RTYPEWB: begin
            regwrite = 1'b1;
            regdst   = 1'b1;
         end
         BEQEX, BNEEX: begin
            alusrca    = 1'b1;
            alucontrol = 3'b110;
            pcsrc      = 2'b01;
         end
         ADDIWB:  regwrite = 1'b1;
         JEX:     pcsrc = 2'b10;
         default: ;
      endcase
   end

   // PC enable combines the fetch increment with taken branches and jumps
   assign pcen = pcwrite
               | ((state_reg == BEQEX) & zero)
               | ((state_reg == BNEEX) & ~zero)
               | (state_reg == JEX);

   assign state   = state_reg;
   assign retired = retired_reg;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller.
// A transaction-level model predicts, per instruction, the state walk,
// the number of cycles each control is active and the retired count.
module tb_multicycle_controller;

   localparam logic [3:0] ST_FETCH   = 4'd0;
   localparam logic [3:0] ST_DECODE  = 4'd1;
   localparam logic [3:0] ST_MEMADR  = 4'd2;
   localparam logic [3:0] ST_MEMRD   = 4'd3;
   localparam logic [3:0] ST_MEMWB   = 4'd4;
   localparam logic [3:0] ST_MEMWR   = 4'd5;
   localparam logic [3:0] ST_RTYPEEX = 4'd6;
   localparam logic [3:0] ST_RTYPEWB = 4'd7;
   localparam logic [3:0] ST_BEQEX   = 4'd8;
   localparam logic [3:0] ST_BNEEX   = 4'd9;
   localparam logic [3:0] ST_ADDIEX  = 4'd10;
   localparam logic [3:0] ST_ADDIWB  = 4'd11;
   localparam logic [3:0] ST_JEX     = 4'd12;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset;
   logic [5:0] op, funct;
   logic       zero, mem_ready;

   logic        iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca, pcen, illegal;
   logic [1:0]  alusrcb, pcsrc;
   logic [2:0]  alucontrol;
   logic [3:0]  state;
   logic [15:0] retired;

   logic        iord_b, memwrite_b, irwrite_b, regdst_b, memtoreg_b, regwrite_b, alusrca_b, pcen_b, illegal_b;
   logic [1:0]  alusrcb_b, pcsrc_b;
   logic [2:0]  alucontrol_b;
   logic [3:0]  state_b;
   logic [2:0]  retired_b;

   int n_checks = 0;
   int n_fail   = 0;
   int exp_ret  = 0;

   multicycle_controller dut (
      .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
      .iord(iord), .memwrite(memwrite), .irwrite(irwrite), .regdst(regdst),
      .memtoreg(memtoreg), .regwrite(regwrite), .alusrca(alusrca), .alusrcb(alusrcb),
      .pcsrc(pcsrc), .alucontrol(alucontrol), .pcen(pcen), .illegal(illegal),
      .state(state), .retired(retired)
   );

   // Reduced build: addi and bne disabled, no memory waiting, 3-bit counter
   multicycle_controller #(.SUPPORT_ADDI(0), .SUPPORT_BNE(0), .MEM_WAIT(0), .CNT_W(3)) dut_b (
      .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
      .iord(iord_b), .memwrite(memwrite_b), .irwrite(irwrite_b), .regdst(regdst_b),
      .memtoreg(memtoreg_b), .regwrite(regwrite_b), .alusrca(alusrca_b), .alusrcb(alusrcb_b),
      .pcsrc(pcsrc_b), .alucontrol(alucontrol_b), .pcen(pcen_b), .illegal(illegal_b),
      .state(state_b), .retired(retired_b)
   );

   // Reference ALU mapping for R-type functs: {legal, alucontrol}
   function automatic logic [3:0] alu_of(input logic [5:0] f);
      case (f)
         6'b100000: return 4'b1010;
         6'b100010: return 4'b1110;
         6'b100100: return 4'b1000;
         6'b100101: return 4'b1001;
         6'b101010: return 4'b1111;
         default:   return 4'b0010;
      endcase
   endfunction

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1; mem_ready = 1'b1; op = OP_J; funct = 6'd0; zero = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;
      exp_ret = 0;
   endtask

   // Run one instruction from FETCH back to FETCH and check it against the model
   task automatic run_instr(input logic [5:0] i_op, input logic [5:0] i_funct,
                            input logic i_zero, input int fw, input int mw);
      logic [3:0] exp_st[$];
      logic [3:0] fa;
      int e_reg = 0, e_memw = 0, e_iord = 0, e_mtr = 0, e_rdst = 0;
      int e_pcen = 1, e_ill = 0, e_ret = 0;
      int o_reg = 0, o_memw = 0, o_iord = 0, o_mtr = 0, o_rdst = 0;
      int o_pcen = 0, o_ill = 0, o_irw = 0;
      int mem_at = -1, rt_at = -1;
      logic [2:0] o_alu = 3'b000;
      fa = alu_of(i_funct);
      for (int i = 0; i <= fw; i++) exp_st.push_back(ST_FETCH);
      exp_st.push_back(ST_DECODE);
      if (i_op == OP_LW) begin
         exp_st.push_back(ST_MEMADR);
         mem_at = exp_st.size();
         for (int i = 0; i <= mw; i++) exp_st.push_back(ST_MEMRD);
         exp_st.push_back(ST_MEMWB);
         e_reg = 1; e_mtr = 1; e_iord = mw + 1; e_ret = 1;
      end else if (i_op == OP_SW) begin
         exp_st.push_back(ST_MEMADR);
         mem_at = exp_st.size();
         for (int i = 0; i <= mw; i++) exp_st.push_back(ST_MEMWR);
         e_memw = mw + 1; e_iord = mw + 1; e_ret = 1;
      end else if (i_op == OP_RTYPE) begin
         rt_at = exp_st.size();
         exp_st.push_back(ST_RTYPEEX);
         if (fa[3]) begin
            exp_st.push_back(ST_RTYPEWB);
            e_reg = 1; e_rdst = 1; e_ret = 1;
         end else begin
            e_ill = 1;
         end
      end else if (i_op == OP_BEQ) begin
         exp_st.push_back(ST_BEQEX);
         e_pcen += int'(i_zero); e_ret = 1;
      end else if (i_op == OP_BNE) begin
         exp_st.push_back(ST_BNEEX);
         e_pcen += int'(!i_zero); e_ret = 1;
      end else if (i_op == OP_ADDI) begin
         exp_st.push_back(ST_ADDIEX);
         exp_st.push_back(ST_ADDIWB);
         e_reg = 1; e_ret = 1;
      end else if (i_op == OP_J) begin
         exp_st.push_back(ST_JEX);
         e_pcen += 1; e_ret = 1;
      end else begin
         e_ill = 1;
      end

      for (int c = 0; c < exp_st.size(); c++) begin
         @(negedge clk);
         op = i_op; funct = i_funct; zero = i_zero;
         if (c <= fw)
            mem_ready = (c == fw);
         else if (mem_at >= 0 && c >= mem_at && c <= mem_at + mw)
            mem_ready = (c == mem_at + mw);
         else
            mem_ready = 1'($urandom_range(0, 1));
         #1;
         n_checks++;
         if (state !== exp_st[c]) begin
            n_fail++;
            $display("FAIL state_seq op=%b cycle %0d: got %0d expected %0d", i_op, c, state, exp_st[c]);
         end
         o_reg += int'(regwrite); o_memw += int'(memwrite); o_iord += int'(iord);
         o_mtr += int'(memtoreg); o_rdst += int'(regdst); o_pcen += int'(pcen);
         o_ill += int'(illegal); o_irw += int'(irwrite);
         if (c == rt_at) o_alu = alucontrol;
      end
      exp_ret = (exp_ret + e_ret) & 16'hffff;
      @(posedge clk); #1;

      n_checks++;
      if (state !== ST_FETCH) begin
         n_fail++; $display("FAIL end_state op=%b: got %0d expected %0d", i_op, state, ST_FETCH);
      end
      n_checks++;
      if (retired !== 16'(exp_ret)) begin
         n_fail++; $display("FAIL retired op=%b: got %0d expected %0d", i_op, retired, exp_ret);
      end
      n_checks++;
      if (o_reg !== e_reg || o_mtr !== e_mtr || o_rdst !== e_rdst) begin
         n_fail++;
         $display("FAIL writeback op=%b: got regwrite/memtoreg/regdst cycles %0d/%0d/%0d expected %0d/%0d/%0d",
                  i_op, o_reg, o_mtr, o_rdst, e_reg, e_mtr, e_rdst);
      end
      n_checks++;
      if (o_memw !== e_memw || o_iord !== e_iord) begin
         n_fail++;
         $display("FAIL memory op=%b: got memwrite/iord cycles %0d/%0d expected %0d/%0d",
                  i_op, o_memw, o_iord, e_memw, e_iord);
      end
      n_checks++;
      if (o_pcen !== e_pcen || o_irw !== 1) begin
         n_fail++;
         $display("FAIL pc_ir op=%b: got pcen/irwrite cycles %0d/%0d expected %0d/1", i_op, o_pcen, o_irw, e_pcen);
      end
      n_checks++;
      if (o_ill !== e_ill) begin
         n_fail++; $display("FAIL illegal op=%b funct=%b: got %0d cycles expected %0d", i_op, i_funct, o_ill, e_ill);
      end
      if (rt_at >= 0) begin
         n_checks++;
         if (o_alu !== fa[2:0]) begin
            n_fail++; $display("FAIL alucontrol funct=%b: got %b expected %b", i_funct, o_alu, fa[2:0]);
         end
      end
      $display("instr op=%b funct=%b zero=%0d fw=%0d mw=%0d cycles=%0d retired=%0d",
               i_op, i_funct, i_zero, fw, mw, exp_st.size(), retired);
   endtask

   task automatic test_reset();
      reset = 1'b1; mem_ready = 1'b1; op = 6'd0; funct = 6'd0; zero = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      if (state !== ST_FETCH || retired !== 16'd0) begin
         n_fail++; $display("FAIL reset_state: got state %0d retired %0d expected 0 0", state, retired);
      end
      n_checks++;
      if ({iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca, alusrcb, pcsrc, alucontrol, pcen, illegal}
          !== 16'b0010000_01_00_010_1_0) begin
         n_fail++;
         $display("FAIL reset_outputs: got %b expected %b",
                  {iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca, alusrcb, pcsrc, alucontrol, pcen, illegal},
                  16'b0010000_01_00_010_1_0);
      end
      mem_ready = 1'b0; #1;
      n_checks++;
      if (irwrite !== 1'b0 || pcen !== 1'b0) begin
         n_fail++; $display("FAIL fetch_wait_gate: got irwrite %0d pcen %0d expected 0 0", irwrite, pcen);
      end
      reset = 1'b0;
      exp_ret = 0;
      $display("reset checked");
   endtask

   task automatic test_lw();
      run_instr(OP_LW, 6'd0, 1'b0, 0, 0);
      run_instr(OP_LW, 6'd0, 1'b1, 2, 2);
   endtask

   task automatic test_sw();
      run_instr(OP_SW, 6'd0, 1'b0, 0, 3);
      run_instr(OP_SW, 6'd0, 1'b0, 0, 0);
   endtask

   task automatic test_branch();
      run_instr(OP_BEQ, 6'd0, 1'b1, 0, 0);
      run_instr(OP_BNE, 6'd0, 1'b1, 0, 0);
      run_instr(OP_BEQ, 6'd0, 1'b0, 1, 0);
      run_instr(OP_BNE, 6'd0, 1'b0, 0, 0);
      run_instr(OP_J,   6'd0, 1'b0, 0, 0);
   endtask

   task automatic test_rtype();
      run_instr(OP_RTYPE, 6'b101010, 1'b0, 0, 0);
      run_instr(OP_RTYPE, 6'b000000, 1'b0, 0, 0);
      run_instr(OP_RTYPE, 6'b100010, 1'b0, 0, 0);
      run_instr(OP_ADDI,  6'd0,      1'b0, 0, 0);
      run_instr(6'b111111, 6'd0,     1'b0, 0, 0);
   endtask

   task automatic test_random();
      logic [5:0] ops[9]    = '{OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_BNE, OP_ADDI, OP_J, 6'b111111, 6'b000011};
      logic [5:0] functs[7] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000000, 6'b111111};
      for (int n = 0; n < 40; n++) begin
         run_instr(ops[$urandom_range(0, 8)], functs[$urandom_range(0, 6)],
                   1'($urandom_range(0, 1)), int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
      end
   endtask

   task automatic test_reset_midwait();
      do_reset();
      for (int k = 0; k < 5; k++) run_instr(OP_J, 6'd0, 1'b0, 0, 0);
      @(negedge clk); op = OP_LW; mem_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk); mem_ready = 1'b0;
      @(negedge clk); #1;
      n_checks++;
      if (state !== ST_MEMRD || retired !== 16'd5) begin
         n_fail++; $display("FAIL midwait_pre: got state %0d retired %0d expected %0d 5", state, retired, ST_MEMRD);
      end
      reset = 1'b1;
      @(posedge clk); #1;
      n_checks++;
      if (state !== ST_FETCH || retired !== 16'd0 || regwrite !== 1'b0 || illegal !== 1'b0) begin
         n_fail++;
         $display("FAIL midwait_reset: got state %0d retired %0d regwrite %0d illegal %0d expected 0 0 0 0",
                  state, retired, regwrite, illegal);
      end
      reset = 1'b0;
      exp_ret = 0;
      $display("reset during MEMRD wait checked");
      run_instr(OP_LW, 6'd0, 1'b0, 0, 0);
   endtask

   task automatic test_disabled_ops();
      logic [5:0] dis[2] = '{OP_ADDI, OP_BNE};
      do_reset();
      for (int k = 0; k < 2; k++) begin
         @(negedge clk); op = dis[k]; mem_ready = 1'b0; #1;
         n_checks++;
         if ({state_b, iord_b, memwrite_b, irwrite_b, regdst_b, memtoreg_b, regwrite_b, alusrca_b,
              alusrcb_b, pcsrc_b, alucontrol_b, pcen_b, illegal_b} !== {ST_FETCH, 16'b0010000_01_00_010_1_0}) begin
            n_fail++;
            $display("FAIL b_fetch_nowait: got %b expected %b",
                     {state_b, iord_b, memwrite_b, irwrite_b, regdst_b, memtoreg_b, regwrite_b, alusrca_b,
                      alusrcb_b, pcsrc_b, alucontrol_b, pcen_b, illegal_b}, {ST_FETCH, 16'b0010000_01_00_010_1_0});
         end
         @(negedge clk); #1;
         n_checks++;
         if (state_b !== ST_DECODE || illegal_b !== 1'b1) begin
            n_fail++; $display("FAIL b_decode_illegal op=%b: got state %0d illegal %0d expected 1 1", dis[k], state_b, illegal_b);
         end
         @(posedge clk); #1;
         n_checks++;
         if (state_b !== ST_FETCH || retired_b !== 3'd0) begin
            n_fail++; $display("FAIL b_after_illegal op=%b: got state %0d retired %0d expected 0 0", dis[k], state_b, retired_b);
         end
         $display("disabled op=%b checked", dis[k]);
      end
   endtask

   task automatic test_wrap();
      for (int k = 0; k < 9; k++) begin
         @(negedge clk); op = OP_J; mem_ready = 1'b0;
         @(negedge clk);
         @(negedge clk);
         @(posedge clk); #1;
         n_checks++;
         if (state_b !== ST_FETCH || retired_b !== 3'((k + 1) % 8)) begin
            n_fail++; $display("FAIL b_wrap k=%0d: got state %0d retired %0d expected 0 %0d", k, state_b, retired_b, (k + 1) % 8);
         end
         $display("j on reduced build retired=%0d", retired_b);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_lw();
      test_sw();
      test_branch();
      test_rtype();
      test_random();
      test_reset_midwait();
      test_disabled_ops();
      test_wrap();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
